// File: rtl/fpu_add_scheduler.sv
// Two-requester round-robin issue scheduler for a fixed-latency FP add datapath.
// Per-requester credits cover in-flight plus buffered results, so the result FIFOs never overflow.
module fpu_add_scheduler #(
   parameter int LAT      = 4,
   parameter int RB_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req1_ready,
   output logic        dp_issue,
   output logic [31:0] dp_a,
   output logic [31:0] dp_b,
   input  logic        dp_res_valid,
   input  logic [31:0] dp_res,
   output logic        rsp0_valid,
   output logic [31:0] rsp0_data,
   input  logic        rsp0_ready,
   output logic        rsp1_valid,
   output logic [31:0] rsp1_data,
   input  logic        rsp1_ready,
   output logic        busy,
   output logic        err_unexpected,
   output logic        err_missing
);
   localparam int            PW    = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
   localparam logic [2:0]    DEPTH = 3'(RB_DEPTH);
   localparam logic [PW-1:0] LAST  = PW'(RB_DEPTH - 1);

   logic [2:0]     cnt [2];
   logic           prio;
   logic [1:0]     elig;
   logic [1:0]     grant;
   logic [1:0]     rsp_hs;
   logic [1:0]     wr;
   logic [1:0]     miss;
   logic           dp_id;
   logic [LAT-1:0] tag_v;
   logic [LAT-1:0] tag_id;
   logic [31:0]    mem [2][RB_DEPTH];
   logic [PW-1:0]  wr_ptr [2];
   logic [PW-1:0]  rd_ptr [2];
   logic [2:0]     fcnt [2];

   // prio high means requester 1 wins a tie; grants are masked while reset is held
   always_comb begin
      elig[0]   = req0_valid && (cnt[0] < DEPTH);
      elig[1]   = req1_valid && (cnt[1] < DEPTH);
      grant[0]  = rst && elig[0] && (!elig[1] || !prio);
      grant[1]  = rst && elig[1] && (!elig[0] || prio);
      rsp_hs[0] = (fcnt[0] != 3'd0) && rsp0_ready;
      rsp_hs[1] = (fcnt[1] != 3'd0) && rsp1_ready;
      wr        = 2'b00;
      miss      = 2'b00;
      if (tag_v[LAT-1]) begin
         if (dp_res_valid) wr[tag_id[LAT-1]]   = 1'b1;
         else              miss[tag_id[LAT-1]] = 1'b1;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign rsp0_valid = (fcnt[0] != 3'd0);
   assign rsp1_valid = (fcnt[1] != 3'd0);
   assign rsp0_data  = mem[0][rd_ptr[0]];
   assign rsp1_data  = mem[1][rd_ptr[1]];
   assign busy       = (cnt[0] != 3'd0) || (cnt[1] != 3'd0) || dp_issue;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio     <= 1'b0;
         dp_issue <= 1'b0;
         dp_id    <= 1'b0;
         dp_a     <= '0;
         dp_b     <= '0;
      end else begin
         dp_issue <= |grant;
         if (|grant) begin
            prio  <= grant[0];
            dp_id <= grant[1];
            dp_a  <= grant[1] ? req1_a : req0_a;
            dp_b  <= grant[1] ? req1_b : req0_b;
         end
      end
   end

   // Stage LAT-1 lines up with the cycle the datapath is due to strobe dp_res_valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_v  <= '0;
         tag_id <= '0;
      end else begin
         tag_v[0]  <= dp_issue;
         tag_id[0] <= dp_id;
         for (int k = 1; k < LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

   // A missing result frees its credit exactly as a consumed response would
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            cnt[i]    <= 3'd0;
            fcnt[i]   <= 3'd0;
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            for (int j = 0; j < RB_DEPTH; j++) mem[i][j] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            cnt[i]  <= cnt[i] + 3'(grant[i]) - 3'(rsp_hs[i]) - 3'(miss[i]);
            fcnt[i] <= fcnt[i] + 3'(wr[i]) - 3'(rsp_hs[i]);
            if (wr[i]) begin
               mem[i][wr_ptr[i]] <= dp_res;
               wr_ptr[i]         <= (wr_ptr[i] == LAST) ? '0 : wr_ptr[i] + 1'b1;
            end
            if (rsp_hs[i]) rd_ptr[i] <= (rd_ptr[i] == LAST) ? '0 : rd_ptr[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_unexpected <= 1'b0;
         err_missing    <= 1'b0;
      end else begin
         if (dp_res_valid && !tag_v[LAT-1]) err_unexpected <= 1'b1;
         if (|miss)                         err_missing    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpu_add_scheduler.sv
// Bench for fpu_add_scheduler: fixed-latency datapath model, result scoreboard, vector table
// and directed sequences for back-pressure, simultaneous handshakes, errors and mid-flight reset.
module tb_fpu_add_scheduler;
   localparam int LAT = 4;
   localparam int RB  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        dp_issue, dp_res_valid;
   logic [31:0] dp_a, dp_b, dp_res;
   logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_data, rsp1_data;
   logic        busy, err_unexpected, err_missing;

   fpu_add_scheduler #(.LAT(LAT), .RB_DEPTH(RB)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .dp_issue(dp_issue), .dp_a(dp_a), .dp_b(dp_b),
      .dp_res_valid(dp_res_valid), .dp_res(dp_res),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .busy(busy), .err_unexpected(err_unexpected), .err_missing(err_missing)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [8];
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp0 [$];
   logic [31:0] exp1 [$];
   logic        drop_nxt = 1'b0;
   logic        inj = 1'b0;
   logic        pv [LAT];
   logic [31:0] pr [LAT];

   function automatic logic [31:0] b2w(input logic x);
      return {31'b0, x};
   endfunction

   // Golden single-precision sums for the operand pairs used here
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 8; i++)
         if (vecs[i].a == a && vecs[i].b == b) return vecs[i].exp;
      return a ^ b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b);
      int   n;
      logic rdy;
      n = 0;
      @(posedge clk); #1;
      if (id == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
      else         begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
      do begin
         @(negedge clk);
         n++;
         rdy = (id == 0) ? req0_ready : req1_ready;
      end while (!rdy && n < 20);
      chk("req_granted", b2w(rdy), 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("issue_valid", b2w(dp_issue), 32'd1);
      chk("issue_a", dp_a, a);
      chk("issue_b", dp_b, b);
   endtask

   // Requester 0 op; cycle numbering: 0 = accept cycle
   task automatic op_lat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int lat;
      lat = 0;
      do_req(0, a, b);
      if (rsp0_valid) lat = 1;
      for (int i = 2; i <= 12; i++) begin
         @(negedge clk);
         if (i == 2) chk("issue_single_cycle", b2w(dp_issue), 32'd0);
         if (rsp0_valid && lat == 0) begin
            lat = i;
            chk("lat_data", rsp0_data, exp);
         end
      end
      chk("accept_to_rsp_latency", 32'(lat), 32'(LAT + 2));
   endtask

   // Datapath model: result strobe LAT cycles after dp_issue
   initial begin
      dp_res_valid = 1'b0;
      dp_res       = '0;
      for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pr[k] = '0; end
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int k = 0; k < LAT; k++) pv[k] = 1'b0;
            dp_res_valid = 1'b0;
         end else begin
            dp_res_valid = pv[LAT-1];
            dp_res       = pr[LAT-1];
            if (drop_nxt && pv[LAT-1]) begin
               dp_res_valid = 1'b0;
               drop_nxt     = 1'b0;
            end
            if (inj) begin
               dp_res_valid = 1'b1;
               dp_res       = 32'hDEADBEEF;
               inj          = 1'b0;
            end
            for (int k = LAT - 1; k > 0; k--) begin pv[k] = pv[k-1]; pr[k] = pr[k-1]; end
            pv[0] = dp_issue;
            pr[0] = fadd(dp_a, dp_b);
         end
      end
   end

   // Scoreboard: push on request handshake, pop and compare on response handshake
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (req0_valid && req0_ready) exp0.push_back(fadd(req0_a, req0_b));
         if (req1_valid && req1_ready) exp1.push_back(fadd(req1_a, req1_b));
         if (rsp0_valid && rsp0_ready) begin
            chk("rsp0_expected", b2w(exp0.size() != 0), 32'd1);
            if (exp0.size() != 0) chk("rsp0_data", rsp0_data, exp0.pop_front());
         end
         if (rsp1_valid && rsp1_ready) begin
            chk("rsp1_expected", b2w(exp1.size() != 0), 32'd1);
            if (exp1.size() != 0) chk("rsp1_data", rsp1_data, exp1.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acc;
      logic seen;
      vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
      vecs[1] = '{1, 32'h40000000, 32'h40000000, 32'h40800000};
      vecs[2] = '{0, 32'h3F800000, 32'h3F800000, 32'h40000000};
      vecs[3] = '{1, 32'h3F000000, 32'h3F000000, 32'h3F800000};
      vecs[4] = '{1, 32'h40400000, 32'h3F800000, 32'h40800000};
      vecs[5] = '{0, 32'h3FC00000, 32'h3F000000, 32'h40000000};
      vecs[6] = '{0, 32'hBF800000, 32'h3F800000, 32'h00000000};
      vecs[7] = '{1, 32'h40800000, 32'h40800000, 32'h41000000};
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;

      // reset state
      #3;
      req0_valid = 1'b1;
      #1;
      chk("rst_req0_ready", b2w(req0_ready), 32'd0);
      chk("rst_dp_issue", b2w(dp_issue), 32'd0);
      chk("rst_dp_a", dp_a, 32'd0);
      chk("rst_dp_b", dp_b, 32'd0);
      chk("rst_rsp0_valid", b2w(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", b2w(rsp1_valid), 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_busy", b2w(busy), 32'd0);
      chk("rst_err_unexpected", b2w(err_unexpected), 32'd0);
      chk("rst_err_missing", b2w(err_missing), 32'd0);
      req0_valid = 1'b0;
      idle(2);
      rst = 1'b1;

      // single op, 1.0 + 2.0
      op_lat(32'h3F800000, 32'h40000000, 32'h40400000);

      // vector table, one op at a time
      for (int i = 0; i < 8; i++) begin
         do_req(vecs[i].id, vecs[i].a, vecs[i].b);
         n = 0;
         while (!(vecs[i].id == 0 ? rsp0_valid : rsp1_valid) && n < 12) begin
            @(negedge clk);
            n++;
         end
         chk("vec_rsp_seen", b2w(n < 12), 32'd1);
         chk("vec_rsp_data", (vecs[i].id == 0) ? rsp0_data : rsp1_data, vecs[i].exp);
      end
      idle(3);
      chk("no_err_unexpected", b2w(err_unexpected), 32'd0);
      chk("no_err_missing", b2w(err_missing), 32'd0);
      chk("idle_busy", b2w(busy), 32'd0);

      // round robin from fresh reset
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      @(posedge clk); #1;
      req0_a = vecs[2].a; req0_b = vecs[2].b;
      req1_a = vecs[1].a; req1_b = vecs[1].b;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k < 4) begin
            chk("rr_grant0", b2w(req0_ready), b2w(k % 2 == 0));
            chk("rr_grant1", b2w(req1_ready), b2w(k % 2 == 1));
         end
         if (k > 0) chk("rr_issue", b2w(dp_issue), 32'd1);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle(16);

      // credit back-pressure on requester 0
      rsp0_ready = 1'b0;
      req0_a = vecs[5].a; req0_b = vecs[5].b;
      req0_valid = 1'b1;
      acc = 0;
      for (int k = 0; k < 12; k++) begin @(negedge clk); if (req0_ready) acc++; end
      chk("credit_accepts_full", 32'(acc), 32'(RB));
      @(posedge clk); #1;
      rsp0_ready = 1'b1;
      @(negedge clk);
      chk("credit_rsp_avail", b2w(rsp0_valid), 32'd1);
      chk("credit_ready_low", b2w(req0_ready), 32'd0);
      @(posedge clk); #1;
      rsp0_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 12; k++) begin @(negedge clk); if (req0_ready) acc++; end
      chk("credit_accepts_after_pop", 32'(acc), 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      rsp0_ready = 1'b1;
      idle(15);

      // simultaneous accept and response on requester 1 at one credit
      rsp1_ready = 1'b0;
      do_req(1, vecs[3].a, vecs[3].b);
      n = 0;
      while (!rsp1_valid && n < 12) begin @(negedge clk); n++; end
      chk("sim_buffered", b2w(rsp1_valid), 32'd1);
      @(posedge clk); #1;
      req1_a = vecs[7].a; req1_b = vecs[7].b;
      req1_valid = 1'b1;
      rsp1_ready = 1'b1;
      @(negedge clk);
      chk("sim_req_ready", b2w(req1_ready), 32'd1);
      chk("sim_rsp_valid", b2w(rsp1_valid), 32'd1);
      @(posedge clk); #1;
      rsp1_ready = 1'b0;
      @(negedge clk);
      chk("sim_no_ready_gap", b2w(req1_ready), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sim_full_after", b2w(req1_ready), 32'd0);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      rsp1_ready = 1'b1;
      idle(15);

      // unexpected result strobe
      inj = 1'b1;
      idle(3);
      chk("err_unexpected_set", b2w(err_unexpected), 32'd1);
      chk("err_missing_clear", b2w(err_missing), 32'd0);
      chk("unexpected_discard", b2w(rsp0_valid | rsp1_valid), 32'd0);
      idle(5);
      chk("err_unexpected_sticky", b2w(err_unexpected), 32'd1);

      // dropped result strobe
      drop_nxt = 1'b1;
      do_req(0, vecs[5].a, vecs[5].b);
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin @(negedge clk); if (rsp0_valid) seen = 1'b1; end
      chk("missing_no_rsp", b2w(seen), 32'd0);
      chk("err_missing_set", b2w(err_missing), 32'd1);
      chk("missing_credit_back", b2w(busy), 32'd0);
      chk("missing_queue", 32'(exp0.size()), 32'd1);
      if (exp0.size() != 0) void'(exp0.pop_front());
      op_lat(vecs[6].a, vecs[6].b, vecs[6].exp);

      // reset with three ops in flight
      @(posedge clk); #1;
      req0_a = vecs[0].a; req0_b = vecs[0].b;
      req1_a = vecs[3].a; req1_b = vecs[3].b;
      req0_valid = 1'b1; req1_valid = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", b2w(busy), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      req0_valid = 1'b1;
      #1;
      chk("mid_rst_req0_ready", b2w(req0_ready), 32'd0);
      chk("mid_rst_dp_issue", b2w(dp_issue), 32'd0);
      chk("mid_rst_dp_a", dp_a, 32'd0);
      chk("mid_rst_dp_b", dp_b, 32'd0);
      chk("mid_rst_busy", b2w(busy), 32'd0);
      chk("mid_rst_rsp_valid", b2w(rsp0_valid | rsp1_valid), 32'd0);
      chk("mid_rst_rsp1_data", rsp1_data, 32'd0);
      chk("mid_rst_err_unexpected", b2w(err_unexpected), 32'd0);
      chk("mid_rst_err_missing", b2w(err_missing), 32'd0);
      req0_valid = 1'b0;
      exp0.delete();
      exp1.delete();
      idle(2);
      rst = 1'b1;
      op_lat(vecs[0].a, vecs[0].b, vecs[0].exp);

      idle(10);
      chk("end_queue0_empty", 32'(exp0.size()), 32'd0);
      chk("end_queue1_empty", 32'(exp1.size()), 32'd0);
      chk("end_err_unexpected", b2w(err_unexpected), 32'd0);
      chk("end_err_missing", b2w(err_missing), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fpu_add_scheduler.md
FPU_ADD_SCHEDULER -- requirements
Module: fpu_add_scheduler

Interface
REQ-001 Parameter LAT, default 4: fixed cycles from dp_issue to matching dp_res_valid; legal 1..16.
REQ-002 Parameter RB_DEPTH, default 2: result-buffer entries per requester; legal 1..4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-007 req0_ready / req1_ready  output  1  operand pair accepted this cycle when valid is also high.
REQ-008 dp_issue  output  1  registered; one operation launched into the add datapath.
REQ-009 dp_a, dp_b  output  32  registered operands accompanying dp_issue.
REQ-010 dp_res_valid  input  1  datapath result strobe.
REQ-011 dp_res  input  32  datapath result.
REQ-012 rsp0_valid / rsp1_valid  output  1  result available for requester n.
REQ-013 rsp0_data / rsp1_data  output  32  result at head of requester n buffer.
REQ-014 rsp0_ready / rsp1_ready  input  1  requester n consumes the result.
REQ-015 busy  output  1  any credit in use or dp_issue high.
REQ-016 err_unexpected, err_missing  output  1  sticky protocol error flags.

Function
REQ-017 Credit counter cnt_n (0..RB_DEPTH) per requester SHALL count in-flight plus buffered results: +1 on request handshake, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-018 Requester n eligible SHALL mean req_n_valid high and cnt_n < RB_DEPTH.
REQ-019 Arbitration SHALL be round-robin: sole eligible requester wins; with both eligible, the requester not granted most recently wins; priority pointer updates only on a grant; after reset requester 0 has priority.
REQ-020 req_n_ready SHALL be high only for the granted requester, at most one per cycle; ready may depend on valid.
REQ-021 On handshake at edge N, dp_issue SHALL be high with the winner's operands for the cycle following edge N, and low otherwise; dp_a/dp_b hold last values when dp_issue low.
REQ-022 A tag pipeline of LAT stages SHALL carry (valid, requester id) in lockstep with dp_issue; its output stage aligns with the expected dp_res_valid.
REQ-023 When dp_res_valid and tag output valid, dp_res SHALL be written into the tagged requester's FIFO; rsp_n_valid rises the next cycle.
REQ-024 Accept-to-rsp_valid latency SHALL be exactly LAT+2 cycles when the buffer is empty; results per requester return in acceptance order.
REQ-025 FIFO full cannot occur on write because of credits; rsp FIFO write and read in the same cycle SHALL both take effect.
REQ-026 dp_res_valid with tag output invalid SHALL set err_unexpected and discard dp_res.
REQ-027 Tag output valid without dp_res_valid SHALL set err_missing, free that credit, and write nothing.
REQ-028 Error flags SHALL remain set until reset.

Reset
REQ-029 rst low SHALL immediately clear: cnt_n, FIFOs, tag pipeline, priority pointer (to 0), dp_issue, dp_a, dp_b, rsp_n_valid, rsp_n_data, busy, err flags; all outputs 0.
REQ-030 Reset mid-operation SHALL drop all in-flight and buffered results; the bench holds dp_res_valid low for LAT cycles after release.

Verification
REQ-031 Single op: req0 a=0x3F800000 b=0x40000000, LAT=4 -> dp_issue one cycle later with those operands; dp_res=0x40400000 at +4 -> rsp0_valid, rsp0_data=0x40400000 at accept+6.
REQ-032 Both valid continuously, rsp ready high -> grants alternate 0,1,0,1 starting with 0; dp_issue high every cycle.
REQ-033 req0 valid, rsp0_ready low, RB_DEPTH=2 -> exactly two accepts, then req0_ready low until one rsp0 handshake, then one further accept.
REQ-034 Simultaneous accept and response on requester 1 at cnt=1 -> cnt stays 1, no ready gap.
REQ-035 dp_res_valid pulsed with empty pipeline -> err_unexpected=1 and stays 1; dropping an expected dp_res_valid -> err_missing=1, credit returned.
REQ-036 rst low with 3 ops in flight -> all outputs 0 immediately; after release, first new accept returns after LAT+2 with correct data.
